// File: rtl/decode_table_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_table_pkg - default table contents, entry helper, FSM state. Rev 1.0
// ----------------------------------------------------------------------------
package decode_table_pkg;

  localparam int unsigned DEFAULT_ENTRIES = 16;

  // Element 0 sits in the least-significant byte.
  localparam logic [15:0][7:0] DEFAULT_TABLE = {
    8'd108, 8'd89, 8'd80, 8'd70, 8'd61, 8'd54, 8'd49, 8'd44,
    8'd42,  8'd37, 8'd30, 8'd25, 8'd20, 8'd13, 8'd8,  8'd3
  };

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Entries beyond the default table read as zero; callers size-cast to DATA_W.
  function automatic logic [7:0] default_entry(input int unsigned idx);
    logic [7:0] val;
    val = 8'd0;
    if (idx < DEFAULT_ENTRIES) val = DEFAULT_TABLE[idx[3:0]];
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_table_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_table_mem - 1W/1R table storage with write-first read bypass. Rev 1.0
// ----------------------------------------------------------------------------
module decode_table_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // A same-cycle write to the read index wins over the stored value.
  assign rd_data_o = (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/decode_table.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_table - self-initialising lookup table, 2-stage valid/ready pipeline.
// Optional runtime writes when DECODE_TABLE_WR_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
module decode_table
  import decode_table_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
`ifdef DECODE_TABLE_WR_EN
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
`endif
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              advance;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign advance     = en_i && (!out_valid_q || out_ready_i);
  assign rd_ready_o  = (state_q == RUN) && advance;
  assign busy_o      = (state_q == INIT);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // The init walk owns the write port until the table is populated.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = DATA_W'(default_entry(32'(cnt_q)));
    if (state_q == INIT) begin
      mem_we = 1'b1;
    end
`ifdef DECODE_TABLE_WR_EN
    else begin
      mem_we    = wr_en_i;
      mem_waddr = wr_addr_i;
      mem_wdata = wr_data_i;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) state_d = RUN;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_addr_d   = s1_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (advance) begin
      s1_valid_d  = rd_valid_i && rd_ready_o;
      s1_addr_d   = rd_addr_i;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  decode_table_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (mem_waddr),
    .wr_data_i (mem_wdata),
    .rd_addr_i (s1_addr_q),
    .rd_data_o (mem_rdata)
  );

endmodule
`default_nettype wire
